// File: rtl/fir_folded_mac.sv
// Folded FIR filter: one signed multiply-accumulate per cycle iterated over all taps,
// circular sample history, write-port coefficients, valid/ready in and out.
module fir_folded_mac #(
  parameter  int TAPS      = 401,
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int OUT_SHIFT = 15,
  localparam int AW        = $clog2(TAPS),
  localparam int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     in_ready,
  input  logic                     coef_wr_en,
  input  logic        [AW-1:0]     coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam logic [AW:0]    TAPS_W = (AW+1)'(TAPS);
  localparam logic [AW-1:0]  LAST   = AW'(TAPS - 1);
  localparam logic [ACC_W:0] ONE    = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [ACC_W:0] RND    = (ONE << OUT_SHIFT) >> 1;
  localparam int             PW     = DATA_W + COEF_W;

  state_t                     state_q, state_d;
  logic        [AW-1:0]       wptr_q, wptr_d;
  logic        [AW-1:0]       k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   out_q, out_d;
  logic signed [DATA_W-1:0]   hist_q [TAPS];
  logic signed [COEF_W-1:0]   coef_q [TAPS];

  logic                       accept;
  logic                       coef_we;
  logic                       last_tap;
  logic        [AW-1:0]       rd_idx;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W:0]      rounded;
  logic signed [ACC_W:0]      shifted;
  logic signed [DATA_W-1:0]   sat;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign out_sample = out_q;

  assign accept   = in_ready && in_valid;
  assign coef_we  = in_ready && coef_wr_en && ({1'b0, coef_wr_addr} < TAPS_W);
  assign last_tap = (k_q == LAST);

  // Newest sample sits at wptr; older taps walk backwards, wrapping modulo TAPS.
  always_comb begin
    rd_idx = '0;
    if (wptr_q >= k_q) rd_idx = wptr_q - k_q;
    else               rd_idx = AW'({1'b0, wptr_q} + TAPS_W - {1'b0, k_q});
  end

  assign prod    = hist_q[rd_idx] * coef_q[k_q];
  assign acc_sum = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign rounded = {acc_sum[ACC_W-1], acc_sum} + RND;
  assign shifted = rounded >>> OUT_SHIFT;

  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (!(&shifted[ACC_W:DATA_W-1]) && (|shifted[ACC_W:DATA_W-1]))
      sat = shifted[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (last_tap) begin
          k_d     = '0;
          out_d   = sat;
          wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept)  hist_q[wptr_q]       <= in_sample;
      if (coef_we) coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule

// File: tb/tb_fir_folded_mac.sv
// Bench for fir_folded_mac: directed cases from the test plan plus randomized traffic
// compared against a sliding-window convolution model.
module tb_fir_folded_mac;

  localparam int TAPS   = 4;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int SHIFT  = 15;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_sample = '0;
  logic                     in_ready;
  logic                     coef_wr_en = 1'b0;
  logic [1:0]               coef_wr_addr = '0;
  logic signed [COEF_W-1:0] coef_wr_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [DATA_W-1:0] out_sample;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  longint hist_m[$];
  longint coef_m[TAPS];

  fir_folded_mac #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint model_out();
    longint acc = 0;
    for (int k = 0; k < hist_m.size(); k++) acc += hist_m[k] * coef_m[k];
    acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic model_clear();
    hist_m.delete();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; coef_wr_en = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    check("coef_wait", in_ready, 1);
    coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
    coef_m[a] = longint'($signed(d));
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic load_coefs(input logic [15:0] h0, h1, h2, h3);
    write_coef(2'd0, h0); write_coef(2'd1, h1);
    write_coef(2'd2, h2); write_coef(2'd3, h3);
  endtask

  // One sample transaction; optional coincident IDLE coef write, a write during MAC,
  // backpressure for `hold` cycles, and a fixed expected value from the test plan.
  task automatic run_sample(input logic [15:0] x, input int hold,
                            input bit cw, input logic [1:0] ca, input logic [15:0] cd,
                            input bit mid_wr, input bit fixed_en, input longint fixed);
    int cyc = 0;
    longint exp, held;
    out_ready = (hold == 0);
    @(negedge clk);
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1; in_sample = x;
    if (cw) begin
      coef_wr_en = 1'b1; coef_wr_addr = ca; coef_wr_data = cd;
      coef_m[ca] = longint'($signed(cd));
    end
    hist_m.push_front(longint'($signed(x)));
    if (hist_m.size() > TAPS) void'(hist_m.pop_back());
    exp = model_out();
    @(negedge clk);
    cyc = 1;
    in_valid = 1'b0; coef_wr_en = 1'b0;
    check("busy_mac", busy, 1);
    while (!out_valid && cyc < 50) begin
      if (mid_wr && cyc == 2) begin
        coef_wr_en = 1'b1; coef_wr_addr = 2'd0; coef_wr_data = 16'sh7FFF;
      end
      @(negedge clk);
      cyc++;
      coef_wr_en = 1'b0;
    end
    check("latency", cyc, TAPS + 1);
    check("out_sample", longint'(out_sample), exp);
    if (fixed_en) check("out_fixed", longint'(out_sample), fixed);
    held = longint'(out_sample);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_stable", longint'(out_sample), held);
        check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    check("in_ready_ret", in_ready, 1);
    check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, c;
    int r;

    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sample", longint'(out_sample), 0);

    // Impulse response
    load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_sample(16'h7FFF, 0, 0, 0, 0, 0, 1, 16'sh4000);
    run_sample(16'h0000, 0, 0, 0, 0, 0, 1, 16'sh2000);
    run_sample(16'h0000, 0, 0, 0, 0, 0, 1, 16'sh1000);
    run_sample(16'h0000, 0, 0, 0, 0, 0, 1, 16'sh0800);
    run_sample(16'h0000, 0, 0, 0, 0, 0, 1, 0);

    // Positive saturation
    do_reset();
    load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) run_sample(16'h7FFF, 0, 0, 0, 0, 0, 0, 0);
    run_sample(16'h7FFF, 0, 0, 0, 0, 0, 1, 32767);

    // Negative saturation
    do_reset();
    load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) run_sample(16'h8000, 0, 0, 0, 0, 0, 0, 0);
    run_sample(16'h8000, 0, 0, 0, 0, 0, 1, -32768);

    // Backpressure and coefficient gating
    do_reset();
    load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_sample(16'h1234, 10, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_sample(16'h0000, 0, 0, 0, 0, 0, 0, 0);
    run_sample(16'h7FFF, 0, 0, 0, 0, 1, 1, 16'sh4000);
    for (int i = 0; i < 4; i++) run_sample(16'h0000, 0, 0, 0, 0, 0, 0, 0);
    run_sample(16'h7FFF, 0, 1, 2'd0, 16'h7FFF, 0, 0, 0);
    check("coef_idle_applied", coef_m[0], 32767);

    // Reset in the middle of MAC
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_sample = 16'sh7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_sample", longint'(out_sample), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_sample(16'h7FFF, 0, 0, 0, 0, 0, 1, 16'sh4000);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) write_coef(2'($urandom_range(0, 3)), 16'($urandom));
      r = $urandom_range(0, 3);
      s = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      c = 16'($urandom);
      run_sample(s, $urandom_range(0, 1) * $urandom_range(1, 3),
                 $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), c,
                 $urandom_range(0, 3) == 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
